// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial bus frame receiver (and the future
// transmitter): frame length, field offsets and the receiver FSM states.
//
// Frame layout, bit 0 is on the wire first:
//   [0] start=0, [4:1] src, [8:5] dst, [10:9] datasize, [74:11] data,
//   [78:75] crc, [79] end=1
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int         FRAME_LEN   = 80;
  localparam logic [1:0] DATASIZE_64 = 2'b11;

  // Field offsets inside the 80-bit frame
  localparam int SRC_LSB  = 1;
  localparam int DST_LSB  = 5;
  localparam int DS_LSB   = 9;
  localparam int DATA_LSB = 11;
  localparam int CRC_LSB  = 75;
  localparam int END_BIT  = 79;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    ACK,
    GAP
  } rx_state_t;

endpackage

// File: rtl/crc4_serial.sv
// ---------------------------------------------------------------------------
// crc4_serial
// Bit-serial CRC-4 LFSR. One message bit is folded in per enabled clock.
// Kept as its own module so the transmitter can share the same polynomial
// handling.
//
// Ports:
//   i_clock   clock, state updates on rising edge
//   i_reset   asynchronous active-high reset, clears the CRC
//   i_clear   synchronous clear back to 4'b0000 (start of a new frame)
//   i_enable  fold i_bit into the CRC this cycle
//   i_bit     message bit
//   i_poly    polynomial low terms, x^4 is implicit
//   o_crc     current CRC value
// ---------------------------------------------------------------------------
module crc4_serial (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_bit,
  input  logic [3:0] i_poly,
  output logic [3:0] o_crc
);

  logic [3:0] r_crc;
  logic       w_feedback;

  assign w_feedback = r_crc[3] ^ i_bit;

  // Galois-style LFSR: shift left, and when the bit leaving the top
  // disagrees with the incoming message bit, subtract (xor) the polynomial.
  // Clear has priority so a new frame always starts from zero.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_crc <= 4'b0000;
    end else if (i_clear) begin
      r_crc <= 4'b0000;
    end else if (i_enable) begin
      r_crc <= {r_crc[2:0], 1'b0} ^ (w_feedback ? i_poly : 4'b0000);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/bus_frame_rx.sv
// ---------------------------------------------------------------------------
// bus_frame_rx
// Receives one 80-bit serial frame (LSB first, one bit per clock), validates
// it, delivers payload and source address through a valid/ready buffer and
// requests an acknowledge drive on the bus for ACK_CYCLES cycles.
//
// Parameters:
//   ACK_CYCLES  cycles ack_drive stays high after an accepted frame (>= 1)
//
// Ports:
//   clock      single clock, rising edge
//   reset      asynchronous active-high reset
//   bus_rx     serial bus sample, idle level 1
//   my_addr    this node's address, matched against frame dst
//   poly       CRC-4 polynomial low terms
//   out_valid  delivered frame available
//   out_ready  consumer takes the frame when out_valid && out_ready
//   out_data   frame payload
//   out_src    frame source address
//   ack_drive  request to drive the bus high as receiver acknowledge
//   frame_err  one-cycle pulse: bad end bit or datasize
//   crc_err    one-cycle pulse: CRC mismatch (0 when CRC checking is off)
//   overrun    one-cycle pulse: good frame arrived while buffer still held
//
// Build option:
//   BUS_FRAME_RX_CRC_CHECK_EN  when defined, CRC is computed and checked;
//                              when undefined, the crc field is ignored and
//                              crc_err is tied low.
// ---------------------------------------------------------------------------
module bus_frame_rx
  import bus_pkg::*;
#(
  parameter int ACK_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_rx,
  input  logic [3:0]  my_addr,
  input  logic [3:0]  poly,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_src,
  output logic        ack_drive,
  output logic        frame_err,
  output logic        crc_err,
  output logic        overrun
);

  localparam logic [7:0] ACK_LAST = 8'(ACK_CYCLES - 1);

  rx_state_t r_state;
  rx_state_t w_nextState;

  logic [FRAME_LEN-1:0] r_frame;
  logic [6:0]           r_bitCnt;
  logic [7:0]           r_ackCnt;
  logic                 r_outValid;
  logic [63:0]          r_outData;
  logic [3:0]           r_outSrc;
  logic                 r_frameErr;
  logic                 r_overrun;

  logic w_startBit;
  logic w_shiftEn;
  logic w_endOk;
  logic w_dsizeOk;
  logic w_crcOk;
  logic w_addrMatch;
  logic w_frameErr;
  logic w_crcErr;
  logic w_overrun;
  logic w_load;

  assign w_startBit  = (r_state == IDLE) && !bus_rx;
  assign w_shiftEn   = w_startBit || (r_state == SHIFT);
  assign w_endOk     = r_frame[END_BIT];
  assign w_dsizeOk   = (r_frame[DS_LSB +: 2] == DATASIZE_64);
  assign w_addrMatch = (r_frame[DST_LSB +: 4] == my_addr);

`ifdef BUS_FRAME_RX_CRC_CHECK_EN
  logic [3:0] w_crc;
  logic       w_crcClear;
  logic       w_crcEnable;
  logic       r_crcErr;
  logic       w_unusedBits;

  // The LFSR sits at zero whenever we are idle, so the first header bit
  // after the start bit is folded into a clean CRC.
  assign w_crcClear  = (r_state == IDLE);
  assign w_crcEnable = (r_state == SHIFT) && (r_bitCnt <= 7'(CRC_LSB - 1));

  crc4_serial u_crc (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (w_crcClear),
    .i_enable (w_crcEnable),
    .i_bit    (bus_rx),
    .i_poly   (poly),
    .o_crc    (w_crc)
  );

  // Frame bit 75+i carries crc bit i, so the field compares directly.
  assign w_crcOk = (r_frame[CRC_LSB +: 4] == w_crc);

  // Error pulse register exists only when CRC checking is built in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_crcErr <= 1'b0;
    end else begin
      r_crcErr <= w_crcErr;
    end
  end

  assign crc_err      = r_crcErr;
  assign w_unusedBits = r_frame[0];
`else
  logic w_unusedBits;

  assign w_crcOk      = 1'b1;
  assign crc_err      = 1'b0;
  assign w_unusedBits = ^{poly, r_frame[CRC_LSB +: 4], r_frame[0], w_crcErr};
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and CHECK decisions. The CHECK ladder is ordered so a
  // malformed frame is never reported as a CRC error, and a frame for
  // another node is dropped without any pulse.
  always_comb begin
    w_nextState = r_state;
    w_frameErr  = 1'b0;
    w_crcErr    = 1'b0;
    w_overrun   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus_rx) w_nextState = SHIFT;
      end
      SHIFT: begin
        if (r_bitCnt == 7'(END_BIT)) w_nextState = CHECK;
      end
      CHECK: begin
        w_nextState = GAP;
        if (!w_endOk || !w_dsizeOk) begin
          w_frameErr = 1'b1;
        end else if (!w_crcOk) begin
          w_crcErr = 1'b1;
        end else if (w_addrMatch) begin
          if (r_outValid && !out_ready) begin
            w_overrun = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_nextState = ACK;
          end
        end
      end
      ACK: begin
        if (r_ackCnt == ACK_LAST) w_nextState = GAP;
      end
      GAP: begin
        // Wait for the sender to release the bus so its trailing low
        // hold is not mistaken for a new start bit.
        if (bus_rx) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Frame shift register and counters. Bits enter at the top and move
  // down, so after the 80th sample bit 0 lands in r_frame[0].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame  <= '0;
      r_bitCnt <= '0;
      r_ackCnt <= '0;
    end else begin
      if (w_shiftEn) begin
        r_frame <= {bus_rx, r_frame[FRAME_LEN-1:1]};
      end
      if (w_startBit) begin
        r_bitCnt <= 7'd1;
      end else if (r_state == SHIFT) begin
        r_bitCnt <= r_bitCnt + 7'd1;
      end else begin
        r_bitCnt <= '0;
      end
      if (r_state == ACK) begin
        r_ackCnt <= r_ackCnt + 8'd1;
      end else begin
        r_ackCnt <= '0;
      end
    end
  end

  // Output buffer and error pulses. A load in CHECK wins over a consume
  // in the same cycle, so the new frame replaces the one being taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSrc   <= '0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_frameErr <= w_frameErr;
      r_overrun  <= w_overrun;
      if (w_load) begin
        r_outValid <= 1'b1;
        r_outData  <= r_frame[DATA_LSB +: 64];
        r_outSrc   <= r_frame[SRC_LSB +: 4];
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_src   = r_outSrc;
  assign ack_drive = (r_state == ACK);
  assign frame_err = r_frameErr;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_bus_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_bus_frame_rx
// Directed bench for bus_frame_rx: builds frames with a reference CRC-4,
// drives them serially and compares outputs at fixed offsets from the end
// bit. Error pulses and acknowledge cycles are also tallied continuously so
// stray or stretched pulses show up in the totals.
// ---------------------------------------------------------------------------
module tb_bus_frame_rx;

  localparam int ACK_N = 2;

  localparam logic [63:0] DATA_A = 64'hDEADBEEF_01234567;
  localparam logic [63:0] DATA_C = 64'h0F1E2D3C_4B5A6978;

  logic        clock;
  logic        reset;
  logic        bus_rx;
  logic [3:0]  my_addr;
  logic [3:0]  poly;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_src;
  logic        ack_drive;
  logic        frame_err;
  logic        crc_err;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  int feCount  = 0;
  int ceCount  = 0;
  int ovCount  = 0;
  int ackCount = 0;

  logic [79:0] frameA;
  logic [79:0] frameFlip;
  logic [79:0] frameDst5;
  logic [79:0] frameNoEnd;
  logic [79:0] frameDs01;
  logic [79:0] frameC;
  logic [63:0] dataFlip;

  bus_frame_rx #(.ACK_CYCLES(ACK_N)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus_rx    (bus_rx),
    .my_addr   (my_addr),
    .poly      (poly),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .ack_drive (ack_drive),
    .frame_err (frame_err),
    .crc_err   (crc_err),
    .overrun   (overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Tally every pulse and every acknowledge cycle outside reset
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_err === 1'b1) feCount++;
      if (crc_err === 1'b1)   ceCount++;
      if (overrun === 1'b1)   ovCount++;
      if (ack_drive === 1'b1) ackCount++;
    end
  end

  // Build a frame and its CRC-4 from the field values
  function automatic logic [79:0] buildFrame(input logic [3:0] src,
                                             input logic [3:0] dst,
                                             input logic [1:0] ds,
                                             input logic [63:0] data,
                                             input logic endBit,
                                             input logic [3:0] pol);
    logic [79:0] f;
    logic [3:0]  c;
    logic        fb;
    f        = '0;
    f[4:1]   = src;
    f[8:5]   = dst;
    f[10:9]  = ds;
    f[74:11] = data;
    c = 4'b0000;
    for (int i = 1; i <= 74; i++) begin
      fb = c[3] ^ f[i];
      c  = {c[2:0], 1'b0} ^ (fb ? pol : 4'b0000);
    end
    f[78:75] = c;
    f[79]    = endBit;
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive a whole frame, then release the bus high. Returns at the falling
  // edge right after the end bit was sampled (DUT is in CHECK).
  task automatic applyStimulus(input logic [79:0] f);
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      bus_rx = f[i];
    end
    @(negedge clock);
    bus_rx = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    bus_rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset     = 1'b1;
    bus_rx    = 1'b1;
    out_ready = 1'b1;
    my_addr   = 4'd3;
    poly      = 4'b0011;

    frameA     = buildFrame(4'd1, 4'd3, 2'b11, DATA_A, 1'b1, 4'b0011);
    frameFlip  = frameA;
    frameFlip[31] = ~frameFlip[31];
    dataFlip   = DATA_A ^ 64'h0000_0000_0010_0000;
    frameDst5  = buildFrame(4'd1, 4'd5, 2'b11, DATA_A, 1'b1, 4'b0011);
    frameNoEnd = buildFrame(4'd1, 4'd3, 2'b11, DATA_A, 1'b0, 4'b0011);
    frameDs01  = buildFrame(4'd1, 4'd3, 2'b01, DATA_A, 1'b1, 4'b0011);
    frameC     = buildFrame(4'd2, 4'd3, 2'b11, DATA_C, 1'b1, 4'b0011);

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_ack",   64'(ack_drive), 64'd0);
    checkOutput("rst_data",  out_data,       64'd0);
    checkOutput("rst_src",   64'(out_src),   64'd0);
    checkOutput("rst_pulses", 64'({frame_err, crc_err, overrun}), 64'd0);
    reset = 1'b0;
    idleCycles(3);

    // Valid frame: delivered one edge after the end bit, ack for ACK_N
    applyStimulus(frameA);
    checkOutput("a_valid_early", 64'(out_valid), 64'd0);
    checkOutput("a_ack_early",   64'(ack_drive), 64'd0);
    @(negedge clock);
    checkOutput("a_valid", 64'(out_valid), 64'd1);
    checkOutput("a_data",  out_data,       DATA_A);
    checkOutput("a_src",   64'(out_src),   64'd1);
    checkOutput("a_ack1",  64'(ack_drive), 64'd1);
    @(negedge clock);
    checkOutput("a_consumed", 64'(out_valid), 64'd0);
    checkOutput("a_ack2",     64'(ack_drive), 64'd1);
    @(negedge clock);
    checkOutput("a_ack_off",  64'(ack_drive), 64'd0);
    idleCycles(4);
    checkOutput("a_ack_total", 64'(ackCount), 64'(ACK_N));

    // Data bit 20 flipped after the CRC was computed
    applyStimulus(frameFlip);
    @(negedge clock);
`ifdef BUS_FRAME_RX_CRC_CHECK_EN
    checkOutput("flip_crc_err", 64'(crc_err),   64'd1);
    checkOutput("flip_valid",   64'(out_valid), 64'd0);
    checkOutput("flip_ack",     64'(ack_drive), 64'd0);
    idleCycles(5);
    checkOutput("flip_ack_total", 64'(ackCount), 64'(ACK_N));
`else
    checkOutput("flip_crc_err", 64'(crc_err),   64'd0);
    checkOutput("flip_valid",   64'(out_valid), 64'd1);
    checkOutput("flip_data",    out_data,       dataFlip);
    idleCycles(5);
    checkOutput("flip_ack_total", 64'(ackCount), 64'(2 * ACK_N));
`endif

    // Frame for another node: silent drop
    applyStimulus(frameDst5);
    @(negedge clock);
    checkOutput("dst_valid",  64'(out_valid), 64'd0);
    checkOutput("dst_ack",    64'(ack_drive), 64'd0);
    checkOutput("dst_pulses", 64'({frame_err, crc_err, overrun}), 64'd0);
    idleCycles(5);

    // Bad end bit, then bad datasize
    applyStimulus(frameNoEnd);
    @(negedge clock);
    checkOutput("noend_ferr", 64'(frame_err), 64'd1);
    checkOutput("noend_ack",  64'(ack_drive), 64'd0);
    @(negedge clock);
    checkOutput("noend_ferr_off", 64'(frame_err), 64'd0);
    idleCycles(5);
    applyStimulus(frameDs01);
    @(negedge clock);
    checkOutput("ds01_ferr",  64'(frame_err), 64'd1);
    checkOutput("ds01_valid", 64'(out_valid), 64'd0);
    idleCycles(5);

    // Held buffer, then overrun, then load-with-consume
    out_ready = 1'b0;
    applyStimulus(frameA);
    @(negedge clock);
    checkOutput("hold_valid", 64'(out_valid), 64'd1);
    idleCycles(6);
    checkOutput("hold_data",  out_data,     DATA_A);
    applyStimulus(frameC);
    @(negedge clock);
    checkOutput("ovr_pulse", 64'(overrun),   64'd1);
    checkOutput("ovr_ack",   64'(ack_drive), 64'd0);
    checkOutput("ovr_data",  out_data,       DATA_A);
    checkOutput("ovr_src",   64'(out_src),   64'd1);
    idleCycles(5);
    applyStimulus(frameC);
    out_ready = 1'b1;
    @(negedge clock);
    checkOutput("swap_valid", 64'(out_valid), 64'd1);
    checkOutput("swap_data",  out_data,       DATA_C);
    checkOutput("swap_src",   64'(out_src),   64'd2);
    checkOutput("swap_ovr",   64'(overrun),   64'd0);
    checkOutput("swap_ack",   64'(ack_drive), 64'd1);
    @(negedge clock);
    checkOutput("swap_consumed", 64'(out_valid), 64'd0);
    idleCycles(5);

    // Reset in the middle of a frame, then a clean frame
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      bus_rx = frameC[i];
    end
    @(negedge clock);
    reset  = 1'b1;
    bus_rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idleCycles(5);
    checkOutput("abort_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_data",  out_data,       64'd0);
    checkOutput("abort_ack",   64'(ack_drive), 64'd0);
    applyStimulus(frameA);
    @(negedge clock);
    checkOutput("clean_valid", 64'(out_valid), 64'd1);
    checkOutput("clean_data",  out_data,       DATA_A);
    checkOutput("clean_src",   64'(out_src),   64'd1);
    idleCycles(6);

    // Totals over the whole run
    checkOutput("total_frame_err", 64'(feCount), 64'd2);
`ifdef BUS_FRAME_RX_CRC_CHECK_EN
    checkOutput("total_crc_err", 64'(ceCount),  64'd1);
    checkOutput("total_ack",     64'(ackCount), 64'(4 * ACK_N));
`else
    checkOutput("total_crc_err", 64'(ceCount),  64'd0);
    checkOutput("total_ack",     64'(ackCount), 64'(5 * ACK_N));
`endif
    checkOutput("total_overrun", 64'(ovCount), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
